// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter in front of a single-port data RAM.
// m0 is the core (ex stage), m1 is an external loader/debug master that
// may lock the bus for up to LOCK_MAX consecutive cycles. Grants are
// combinational; read data returns one cycle after the granted address.
// Optional feature: define RAM_ARB_RR_EN to alternate grants on contended
// idle cycles (otherwise the core always wins contention).

`ifndef RAMAddrBus
`define RAMAddrBus 31:0
`endif
`ifndef RAMDataBus
`define RAMDataBus 31:0
`endif

module ram_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_m0_req,
  input  logic               i_m0_we,
  input  logic [`RAMAddrBus] i_m0_addr,
  input  logic [`RAMDataBus] i_m0_w_data,
  output logic               o_m0_gnt,
  output logic               o_m0_r_valid,
  output logic [`RAMDataBus] o_m0_r_data,
  output logic               o_hold_flag,
  input  logic               i_m1_req,
  input  logic               i_m1_we,
  input  logic               i_m1_lock,
  input  logic [`RAMAddrBus] i_m1_addr,
  input  logic [`RAMDataBus] i_m1_w_data,
  output logic               o_m1_gnt,
  output logic               o_m1_r_valid,
  output logic [`RAMDataBus] o_m1_r_data,
  output logic               o_ram_we,
  output logic [`RAMAddrBus] o_ram_addr,
  output logic [`RAMDataBus] o_ram_w_data,
  input  logic [`RAMDataBus] i_ram_r_data
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    M1_LOCK = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             no_relock, no_relock_nxt;
  logic             gnt0, gnt1;
  logic             cnt_hit;
  logic             m1_wins;
  logic             m0_vld_p1, m1_vld_p1;

`ifdef RAM_ARB_RR_EN
  // 0: m0 preferred on the next contended idle cycle, 1: m1 preferred
  logic rr_ptr, rr_ptr_nxt;
  assign m1_wins = rr_ptr;
`else
  assign m1_wins = 1'b0;
`endif

  // This locked cycle is the LOCK_MAX-th consecutive m1 grant
  assign cnt_hit = (lock_cnt >= CNT_W'(LOCK_MAX - 1));

  // Grant decision and next-state logic
  always_comb begin
    state_nxt     = state;
    lock_cnt_nxt  = lock_cnt;
    no_relock_nxt = no_relock;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
`ifdef RAM_ARB_RR_EN
    rr_ptr_nxt    = rr_ptr;
`endif
    if (!i_reset) begin
      case (state)
        IDLE: begin
          lock_cnt_nxt = '0;
          if (i_m0_req && i_m1_req) begin
            gnt1 = m1_wins;
            gnt0 = !m1_wins;
`ifdef RAM_ARB_RR_EN
            rr_ptr_nxt = !rr_ptr;
`endif
          end else begin
            gnt0 = i_m0_req;
            gnt1 = i_m1_req;
          end
          // Core got its turn (or does not want one): m1 may lock again
          if (gnt0 || !i_m0_req) no_relock_nxt = 1'b0;
          if (gnt1 && i_m1_lock && !no_relock) begin
            if (LOCK_MAX > 1) begin
              state_nxt    = M1_LOCK;
              lock_cnt_nxt = CNT_W'(1);
            end else begin
              no_relock_nxt = 1'b1;
            end
          end
        end
        M1_LOCK: begin
          gnt1         = i_m1_req;
          lock_cnt_nxt = (lock_cnt == CNT_W'(LOCK_MAX)) ? lock_cnt : lock_cnt + 1'b1;
          if (!i_m1_lock || !i_m1_req || cnt_hit) begin
            // Releasing cycle: the core may take the bus if m1 let go
            gnt0      = i_m0_req && !i_m1_req;
            state_nxt = IDLE;
`ifdef RAM_ARB_RR_EN
            rr_ptr_nxt = 1'b0;
`endif
            if (i_m1_req && i_m1_lock && cnt_hit) no_relock_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      no_relock <= 1'b0;
`ifdef RAM_ARB_RR_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      lock_cnt  <= lock_cnt_nxt;
      no_relock <= no_relock_nxt;
`ifdef RAM_ARB_RR_EN
      rr_ptr    <= rr_ptr_nxt;
`endif
    end
  end

  // Stage p0 -> p1: remember which master's read is returning next cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      m0_vld_p1 <= 1'b0;
      m1_vld_p1 <= 1'b0;
    end else begin
      m0_vld_p1 <= gnt0 && !i_m0_we;
      m1_vld_p1 <= gnt1 && !i_m1_we;
    end
  end

  assign o_m0_gnt     = gnt0;
  assign o_m1_gnt     = gnt1;
  assign o_hold_flag  = !i_reset && i_m0_req && !gnt0;

  assign o_ram_we     = gnt0 ? i_m0_we     : (gnt1 ? i_m1_we     : 1'b0);
  assign o_ram_addr   = gnt0 ? i_m0_addr   : (gnt1 ? i_m1_addr   : '0);
  assign o_ram_w_data = gnt0 ? i_m0_w_data : (gnt1 ? i_m1_w_data : '0);

  // A read in flight when reset arrives is dropped
  assign o_m0_r_valid = m0_vld_p1 && !i_reset;
  assign o_m1_r_valid = m1_vld_p1 && !i_reset;
  assign o_m0_r_data  = o_m0_r_valid ? i_ram_r_data : '0;
  assign o_m1_r_data  = o_m1_r_valid ? i_ram_r_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural
// ownership model compared every cycle, a small RAM behind the arbiter,
// and hand-computed literal expectations for the key scenarios.

module tb_ram_arbiter;

  localparam int LOCK_MAX = 16;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic        m0_gnt, m0_rv, m1_gnt, m1_rv, hold;
  logic [31:0] m0_rd, m1_rd;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wd;
  logic [31:0] ram_rd;

  int checks = 0;
  int passes = 0;

  ram_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_w_data(m0_wd),
    .o_m0_gnt(m0_gnt), .o_m0_r_valid(m0_rv), .o_m0_r_data(m0_rd), .o_hold_flag(hold),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_lock(m1_lock),
    .i_m1_addr(m1_addr), .i_m1_w_data(m1_wd),
    .o_m1_gnt(m1_gnt), .o_m1_r_valid(m1_rv), .o_m1_r_data(m1_rd),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_w_data(ram_wd),
    .i_ram_r_data(ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background RAM contents for never-written words
  function automatic logic [31:0] seed(input logic [7:0] idx);
    return (idx == 8'd4) ? 32'hDEADBEEF : {24'hA50000, idx};
  endfunction

  // Data RAM: one-cycle read latency
  logic [31:0]  ram [0:255];
  logic [255:0] ram_wr = '0;
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr[9:2]]    <= ram_wd;
      ram_wr[ram_addr[9:2]] <= 1'b1;
    end
    ram_rd <= ram_wr[ram_addr[9:2]] ? ram[ram_addr[9:2]] : seed(ram_addr[9:2]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] wmem [int];
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (wmem.exists(int'(a[9:2]))) return wmem[int'(a[9:2])];
    return seed(a[9:2]);
  endfunction

  bit          m_locked = 0;   // m1 currently owns the bus under lock
  int          m_run    = 0;   // consecutive locked m1 grants so far
  bit          m_block  = 0;   // m1 may not lock until the core had a turn
  bit          m_pref1  = 0;   // round-robin: m1 preferred on contention
  bit          pend0 = 0, pend1 = 0;
  logic [31:0] pend0_val = '0, pend1_val = '0;

  initial begin
    int          owner;        // 0 none, 1 core, 2 external master
    bit          rel, blk;
    logic        e_we, e_hold, e_v0, e_v1;
    logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
    forever begin
      @(negedge clk);
      owner = 0;
      rel   = 0;
      if (!rst) begin
        if (m_locked) begin
          rel = !m1_lock || !m1_req || (m_run + 1 >= LOCK_MAX);
          if (m1_req) owner = 2;
          else if (rel && m0_req) owner = 1;
        end else if (m0_req && m1_req) begin
          owner = (RR && m_pref1) ? 2 : 1;
        end else if (m0_req) owner = 1;
        else if (m1_req) owner = 2;
      end
      e_we   = (owner == 1) ? m0_we   : (owner == 2) ? m1_we   : 1'b0;
      e_addr = (owner == 1) ? m0_addr : (owner == 2) ? m1_addr : 32'h0;
      e_wd   = (owner == 1) ? m0_wd   : (owner == 2) ? m1_wd   : 32'h0;
      e_hold = !rst && m0_req && (owner != 1);
      e_v0   = pend0 && !rst;
      e_v1   = pend1 && !rst;
      e_rd0  = e_v0 ? pend0_val : 32'h0;
      e_rd1  = e_v1 ? pend1_val : 32'h0;

      chk("gnt0", m0_gnt, (owner == 1));
      chk("gnt1", m1_gnt, (owner == 2));
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wd, e_wd);
      chk("hold", hold, e_hold);
      chk("rvalid0", m0_rv, e_v0);
      chk("rvalid1", m1_rv, e_v1);
      chk("rdata0", m0_rd, e_rd0);
      chk("rdata1", m1_rd, e_rd1);

      if (rst) begin
        m_locked = 0; m_run = 0; m_block = 0; m_pref1 = 0;
        pend0 = 0; pend1 = 0;
      end else begin
        pend0 = (owner == 1) && !m0_we;
        pend1 = (owner == 2) && !m1_we;
        if (pend0) pend0_val = mem_val(m0_addr);
        if (pend1) pend1_val = mem_val(m1_addr);
        if (e_we) wmem[int'(e_addr[9:2])] = e_wd;
        if (m_locked) begin
          if (rel) begin
            if (m1_req && m1_lock) m_block = 1;
            m_locked = 0; m_run = 0; m_pref1 = 0;
          end else m_run++;
        end else begin
          blk = m_block;
          if (m0_req && m1_req) m_pref1 = !m_pref1;
          if (owner == 1 || !m0_req) m_block = 0;
          if (owner == 2 && m1_lock && !blk) begin
            m_locked = 1; m_run = 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic rs,
                     input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic l1,
                     input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    rst = rs;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wd = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wd = d1;
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [3:0] pat;
    int n1, nh;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wd = 0;

    // Reset with both masters requesting
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      chk("rst_gnt0", m0_gnt, 1'b0);
      chk("rst_gnt1", m1_gnt, 1'b0);
      chk("rst_hold", hold, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
    end
    idle();
    chk("post_rst_rvalid0", m0_rv, 1'b0);
    chk("post_rst_rvalid1", m1_rv, 1'b0);

    // Core read of 0x10, then back-to-back read of 0x14
    cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd_gnt0", m0_gnt, 1'b1);
    chk("rd_hold", hold, 1'b0);
    chk("rd_ram_addr", ram_addr, 32'h10);
    cyc(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd_rvalid0", m0_rv, 1'b1);
    chk("rd_rdata0", m0_rd, 32'hDEADBEEF);
    idle();
    chk("b2b_rvalid0", m0_rv, 1'b1);
    chk("b2b_rdata0", m0_rd, 32'hA5000005);

    // Four contended cycles without lock
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
      pat[i] = m1_gnt;
    end
    chk("contend_m1_pattern", {28'h0, pat}, RR ? 32'hA : 32'h0);
    idle();

    // Locked m1 burst writing 1..5 to 0x0..0x10, core requesting behind it
    n1 = 0; nh = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, (i > 0), 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 1'b1, 32'(i * 4), 32'(i + 1));
      n1 += int'(m1_gnt);
      nh += int'(hold);
    end
    chk("lock_m1_grants", n1, 5);
    chk("lock_hold_cycles", nh, 4);
    cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("lock_drop_gnt0", m0_gnt, 1'b1);
    idle();
    chk("lock_readback", m0_rd, 32'h3);

    // m1 keeps lock and request for 40 cycles; forced release after LOCK_MAX
    n1 = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, (i > 0), 1'b0, 32'h84, 32'h0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
      if (i < 16) n1 += int'(m1_gnt);
      if (i == 16) begin
        chk("maxlock_gnt0", m0_gnt, 1'b1);
        chk("maxlock_gnt1", m1_gnt, 1'b0);
      end
    end
    chk("maxlock_m1_grants", n1, 16);
    idle();
    idle();

    // Lock dropped while m1 still requests: m1 keeps that cycle, core next
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h34, 32'h0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0);
    chk("in_lock_gnt1", m1_gnt, 1'b1);
    chk("in_lock_hold", hold, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'h34, 32'h0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    chk("unlock_gnt1", m1_gnt, 1'b1);
    chk("unlock_gnt0", m0_gnt, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'h34, 32'h0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    chk("after_unlock_gnt0", m0_gnt, 1'b1);
    idle();

    // m1 write produces no read-valid
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h55);
    chk("wr_ram_we", ram_we, 1'b1);
    chk("wr_ram_addr", ram_addr, 32'h100);
    idle();
    chk("wr_no_rvalid1", m1_rv, 1'b0);

    // m1 read granted, reset asserted the following cycle
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    chk("pre_rst_gnt1", m1_gnt, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    chk("mid_rst_gnt0", m0_gnt, 1'b0);
    chk("mid_rst_gnt1", m1_gnt, 1'b0);
    chk("mid_rst_rvalid1", m1_rv, 1'b0);
    chk("mid_rst_hold", hold, 1'b0);
    idle();
    chk("after_rst_rvalid1", m1_rv, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    chk("after_rst_idle_gnt0", m0_gnt, 1'b1);
    idle();
    idle();

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
